// File: rtl/mrd_pkg.sv
// Shared definitions for the mixed-radix DFT memory: top-FSM encodings,
// bank geometry, the sink FSM state type and the bank one-hot helper.
package mrd_pkg;

    localparam int unsigned NBANK  = 7;
    localparam int unsigned IDXW   = 3;
    localparam int unsigned FSMW   = 3;
    localparam int unsigned DW_DEF = 18;
    localparam int unsigned AW_DEF = 12;

    // Top-level FSM encodings
    localparam logic [FSMW-1:0] FSM_IDLE        = 3'd0;
    localparam logic [FSMW-1:0] FSM_SINK        = 3'd1;
    localparam logic [FSMW-1:0] FSM_WAIT_TO_RD  = 3'd2;
    localparam logic [FSMW-1:0] FSM_RD          = 3'd3;
    localparam logic [FSMW-1:0] FSM_WAIT_WR_END = 3'd4;
    localparam logic [FSMW-1:0] FSM_SOURCE      = 3'd5;

    // Sink write-engine states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_FLUSH = 2'd2
    } sink_state_e;

    // Bank index to one-hot enable; bank 0 sits at the MSB.
    function automatic logic [NBANK-1:0] bank_onehot(input logic [IDXW-1:0] idx);
        logic [NBANK-1:0] msb;
        msb         = {1'b1, {(NBANK-1){1'b0}}};
        bank_onehot = msb >> idx;
    endfunction

endpackage

// File: rtl/mrd_fsmsink_mod7_addr_cnt.sv
// Sequential mod-7 bank index / bank address counter.
// Walks frame index n as (n mod 7, n div 7) without a divider.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clr         - restart at index 0 (with inc: land on index 1, addr 0)
//   inc         - advance by one sample
//   bank_idx    - current bank index 0..6
//   bank_addr   - current address within the bank
module mod7_addr_cnt
    import mrd_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            inc,
    output logic [IDXW-1:0] bank_idx,
    output logic [AW-1:0]   bank_addr
);

    logic [IDXW-1:0] idx_q, idx_d;
    logic [AW-1:0]   addr_q, addr_d;

    // Next index/address: clear takes priority; clear+inc means sample 0
    // was consumed this cycle, so the counter points at sample 1.
    always_comb begin
        idx_d  = idx_q;
        addr_d = addr_q;
        if (clr) begin
            addr_d = '0;
            idx_d  = inc ? IDXW'(1) : '0;
        end else if (inc) begin
            if (idx_q == IDXW'(NBANK-1)) begin
                idx_d  = '0;
                addr_d = addr_q + AW'(1);
            end else begin
                idx_d  = idx_q + IDXW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            addr_q <= '0;
        end else begin
            idx_q  <= idx_d;
            addr_q <= addr_d;
        end
    end

    assign bank_idx  = idx_q;
    assign bank_addr = addr_q;

endmodule

// File: rtl/mrd_fsmsink.sv
// Sink-side write engine: receives one frame of dftpts complex samples on a
// sop/eop/valid stream while the top FSM is in Sink and writes sample n to
// bank (n mod 7) at address (n div 7). Reports completion and malformed frames.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   fsm                  - top-level FSM state (Sink = 1)
//   dftpts               - frame length, sampled at sop
//   in_valid/sop/eop     - input stream qualifiers
//   in_dreal/in_dimag    - input sample
//   wren                 - one-hot bank write enable (bank0 = MSB)
//   bank_addr_sink       - write address within the bank
//   wrdata_real/imag     - write data
//   sink_ongoing         - frame reception in progress
//   sink_end             - pulse: correct frame fully written
//   err_len              - pulse: malformed frame
//   cnt_sink             - samples written in the current frame
module mrd_fsmsink
    import mrd_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [FSMW-1:0]  fsm,
    input  logic [AW-1:0]    dftpts,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [DW-1:0]    in_dreal,
    input  logic [DW-1:0]    in_dimag,
    output logic [NBANK-1:0] wren,
    output logic [AW-1:0]    bank_addr_sink,
    output logic [DW-1:0]    wrdata_real,
    output logic [DW-1:0]    wrdata_imag,
    output logic             sink_ongoing,
    output logic             sink_end,
    output logic             err_len,
    output logic [AW-1:0]    cnt_sink
);

    sink_state_e      state_q, state_d;
    logic [NBANK-1:0] wren_q, wren_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wrr_q, wrr_d;
    logic [DW-1:0]    wri_q, wri_d;
    logic             ongoing_q, ongoing_d;
    logic             sink_end_q, sink_end_d;
    logic             err_len_q, err_len_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    len_q, len_d;

    logic             cnt_clr, cnt_inc;
    logic             do_start, do_write;
    logic [IDXW-1:0]  bank_idx;
    logic [AW-1:0]    bank_addr;
    logic [AW-1:0]    cnt_plus1;

    assign cnt_plus1 = cnt_q + AW'(1);

    mod7_addr_cnt #(.AW(AW)) u_addr_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cnt_clr),
        .inc       (cnt_inc),
        .bank_idx  (bank_idx),
        .bank_addr (bank_addr)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        wren_d     = '0;
        addr_d     = addr_q;
        wrr_d      = wrr_q;
        wri_d      = wri_q;
        sink_end_d = 1'b0;
        err_len_d  = 1'b0;
        cnt_d      = cnt_q;
        len_d      = len_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        do_start   = 1'b0;
        do_write   = 1'b0;

        if (fsm != FSM_SINK) begin
            state_d = S_IDLE;
        end else if (in_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (in_sop) do_start = 1'b1;
                end
                S_RECV: begin
                    if (in_sop) begin
                        // Early sop aborts the current frame and restarts.
                        err_len_d = 1'b1;
                        do_start  = 1'b1;
                    end else begin
                        do_write = 1'b1;
                        if (in_eop) begin
                            state_d = S_IDLE;
                            if (cnt_plus1 == len_q) sink_end_d = 1'b1;
                            else                    err_len_d  = 1'b1;
                        end else if (cnt_plus1 == len_q) begin
                            // Frame full but no eop: drop the rest until eop.
                            err_len_d = 1'b1;
                            state_d   = S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (in_sop)      do_start = 1'b1;
                    else if (in_eop) state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Sample 0 of a new frame: fixed bank 0, address 0
        if (do_start) begin
            wren_d  = bank_onehot(IDXW'(0));
            addr_d  = '0;
            cnt_d   = AW'(1);
            len_d   = dftpts;
            cnt_clr = 1'b1;
            cnt_inc = 1'b1;
            state_d = S_RECV;
            if (in_eop) begin
                state_d = S_IDLE;
                if (dftpts == AW'(1)) sink_end_d = 1'b1;
                else                  err_len_d  = 1'b1;
            end
        end

        if (do_write) begin
            wren_d  = bank_onehot(bank_idx);
            addr_d  = bank_addr;
            cnt_d   = cnt_plus1;
            cnt_inc = 1'b1;
        end

        if (do_start || do_write) begin
            wrr_d = in_dreal;
            wri_d = in_dimag;
        end

        ongoing_d = (state_d == S_RECV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wren_q     <= '0;
            addr_q     <= '0;
            wrr_q      <= '0;
            wri_q      <= '0;
            ongoing_q  <= 1'b0;
            sink_end_q <= 1'b0;
            err_len_q  <= 1'b0;
            cnt_q      <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            wrr_q      <= wrr_d;
            wri_q      <= wri_d;
            ongoing_q  <= ongoing_d;
            sink_end_q <= sink_end_d;
            err_len_q  <= err_len_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
        end
    end

    assign wren           = wren_q;
    assign bank_addr_sink = addr_q;
    assign wrdata_real    = wrr_q;
    assign wrdata_imag    = wri_q;
    assign sink_ongoing   = ongoing_q;
    assign sink_end       = sink_end_q;
    assign err_len        = err_len_q;
    assign cnt_sink       = cnt_q;

endmodule

// File: tb/tb_mrd_fsmsink.sv
// Self-checking bench for mrd_fsmsink: directed frame scenarios with random
// data and gaps, checked every cycle against a frame-level reference model.
module tb_mrd_fsmsink;

    localparam int unsigned DW = 18;
    localparam int unsigned AW = 12;
    localparam logic [2:0] F_IDLE = 3'd0;
    localparam logic [2:0] F_SINK = 3'd1;
    localparam logic [2:0] F_RD   = 3'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    fsm;
    logic [AW-1:0] dftpts;
    logic          in_valid, in_sop, in_eop;
    logic [DW-1:0] in_dreal, in_dimag;
    logic [6:0]    wren;
    logic [AW-1:0] bank_addr_sink;
    logic [DW-1:0] wrdata_real, wrdata_imag;
    logic          sink_ongoing, sink_end, err_len;
    logic [AW-1:0] cnt_sink;

    always #5 clk = ~clk;

    mrd_fsmsink dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fsm            (fsm),
        .dftpts         (dftpts),
        .in_valid       (in_valid),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .in_dreal       (in_dreal),
        .in_dimag       (in_dimag),
        .wren           (wren),
        .bank_addr_sink (bank_addr_sink),
        .wrdata_real    (wrdata_real),
        .wrdata_imag    (wrdata_imag),
        .sink_ongoing   (sink_ongoing),
        .sink_end       (sink_end),
        .err_len        (err_len),
        .cnt_sink       (cnt_sink)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: frame index, latched length, frame-open flag, last write
    int            m_n, m_len;
    bit            m_in_frame;
    logic [6:0]    m_wren;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_dr, m_di;
    bit            m_end, m_err;

    // Per-scenario observations
    int            st_wr, st_end, st_err;
    logic [6:0]    wq[$];
    logic [AW-1:0] aq[$];

    logic [6:0] exp_w1 [12] = '{7'h40, 7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h01,
                                7'h40, 7'h20, 7'h10, 7'h08, 7'h04};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_len = 0; m_in_frame = 0;
        m_wren = '0; m_addr = '0; m_dr = '0; m_di = '0;
        m_end = 0; m_err = 0;
    endtask

    task automatic model_write(input logic [DW-1:0] dr, input logic [DW-1:0] di);
        m_wren = 7'(7'h40 >> (m_n % 7));
        m_addr = AW'(m_n / 7);
        m_dr   = dr;
        m_di   = di;
        m_n++;
    endtask

    task automatic model_step(input bit v, input bit sop, input bit eop, input logic [2:0] f,
                              input logic [DW-1:0] dr, input logic [DW-1:0] di);
        m_wren = '0; m_end = 0; m_err = 0;
        if (f != F_SINK) begin
            m_in_frame = 0;
        end else if (v) begin
            if (sop) begin
                if (m_in_frame) m_err = 1;
                m_len = int'(dftpts);
                m_n   = 0;
                model_write(dr, di);
                m_in_frame = 1;
                if (eop) begin
                    m_in_frame = 0;
                    if (m_len == 1) m_end = 1; else m_err = 1;
                end
            end else if (m_in_frame) begin
                model_write(dr, di);
                if (eop) begin
                    m_in_frame = 0;
                    if (m_n == m_len) m_end = 1; else m_err = 1;
                end else if (m_n == m_len) begin
                    m_err = 1;
                    m_in_frame = 0;
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wren"}, 32'(wren), 32'h0);
        check({tag, "_addr"}, 32'(bank_addr_sink), 32'h0);
        check({tag, "_wrr"},  32'(wrdata_real), 32'h0);
        check({tag, "_wri"},  32'(wrdata_imag), 32'h0);
        check({tag, "_ongoing"}, 32'(sink_ongoing), 32'h0);
        check({tag, "_end"},  32'(sink_end), 32'h0);
        check({tag, "_err"},  32'(err_len), 32'h0);
        check({tag, "_cnt"},  32'(cnt_sink), 32'h0);
    endtask

    // One clock: drive at negedge, compare just after posedge
    task automatic cyc(input bit v, input bit sop, input bit eop, input logic [2:0] f);
        logic [DW-1:0] dr, di;
        dr = DW'($urandom);
        di = DW'($urandom);
        @(negedge clk);
        in_valid = v; in_sop = sop; in_eop = eop; fsm = f;
        in_dreal = dr; in_dimag = di;
        model_step(v, sop, eop, f, dr, di);
        @(posedge clk);
        #1;
        check("wren",      32'(wren), 32'(m_wren));
        check("addr",      32'(bank_addr_sink), 32'(m_addr));
        check("wrdata_re", 32'(wrdata_real), 32'(m_dr));
        check("wrdata_im", 32'(wrdata_imag), 32'(m_di));
        check("sink_end",  32'(sink_end), 32'(m_end));
        check("err_len",   32'(err_len), 32'(m_err));
        check("ongoing",   32'(sink_ongoing), 32'(m_in_frame));
        check("cnt_sink",  32'(cnt_sink), 32'(m_n));
        if (wren != 0) begin
            st_wr++;
            wq.push_back(wren);
            aq.push_back(bank_addr_sink);
        end
        if (sink_end) st_end++;
        if (err_len)  st_err++;
    endtask

    task automatic clear_stats();
        st_wr = 0; st_end = 0; st_err = 0;
        wq.delete(); aq.delete();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, F_SINK);
    endtask

    // Send nsamp samples starting with sop; eop on index eop_at (-1: none);
    // fsm forced to Idle from sample drop_at on (-1: never).
    task automatic send(input int len_cfg, input int nsamp, input int eop_at, input int gap_pct,
                        input logic [2:0] f_main, input int drop_at);
        logic [2:0] f;
        dftpts = AW'(len_cfg);
        for (int i = 0; i < nsamp; i++) begin
            f = (drop_at >= 0 && i >= drop_at) ? F_IDLE : f_main;
            for (int g = 0; g < 4; g++) begin
                if (int'($urandom_range(99)) < gap_pct) cyc(0, 0, 0, f);
            end
            cyc(1, i == 0, i == eop_at, f);
        end
    endtask

    initial begin
        rst_n = 1'b0; fsm = F_SINK; dftpts = AW'(12);
        in_valid = 0; in_sop = 0; in_eop = 0; in_dreal = '0; in_dimag = '0;
        model_reset();
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 12-point frame, back to back
        clear_stats();
        send(12, 12, 11, 0, F_SINK, -1);
        idle(2);
        check("s1_writes", 32'(st_wr), 32'd12);
        check("s1_end", 32'(st_end), 32'd1);
        check("s1_err", 32'(st_err), 32'd0);
        check("s1_cnt", 32'(cnt_sink), 32'd12);
        for (int i = 0; i < 12 && i < wq.size(); i++) begin
            check("s1_wren_seq", 32'(wq[i]), 32'(exp_w1[i]));
            check("s1_addr_seq", 32'(aq[i]), (i < 7) ? 32'd0 : 32'd1);
        end

        // 1200-point frame with random gaps
        clear_stats();
        send(1200, 1200, 1199, 30, F_SINK, -1);
        idle(2);
        check("s2_writes", 32'(st_wr), 32'd1200);
        check("s2_end", 32'(st_end), 32'd1);
        if (wq.size() > 0) begin
            check("s2_last_wren", 32'(wq[$]), 32'h10);
            check("s2_last_addr", 32'(aq[$]), 32'd171);
        end

        // Early eop, then a correct frame
        clear_stats();
        send(12, 6, 5, 0, F_SINK, -1);
        idle(1);
        check("s3_writes", 32'(st_wr), 32'd6);
        check("s3_err", 32'(st_err), 32'd1);
        check("s3_end", 32'(st_end), 32'd0);
        clear_stats();
        send(12, 12, 11, 10, F_SINK, -1);
        idle(1);
        check("s3b_end", 32'(st_end), 32'd1);

        // Over-long frame: 15 samples, eop on the 15th
        clear_stats();
        send(12, 15, 14, 0, F_SINK, -1);
        idle(1);
        check("s4_writes", 32'(st_wr), 32'd12);
        check("s4_err", 32'(st_err), 32'd1);
        check("s4_end", 32'(st_end), 32'd0);
        check("s4_ongoing", 32'(sink_ongoing), 32'd0);

        // Frame under fsm=Rd, then fsm drop at sample 7, then clean frame
        clear_stats();
        send(12, 12, 11, 0, F_RD, -1);
        check("s5_rd_writes", 32'(st_wr), 32'd0);
        clear_stats();
        send(12, 12, 11, 0, F_SINK, 7);
        check("s5_drop_writes", 32'(st_wr), 32'd7);
        check("s5_drop_end", 32'(st_end), 32'd0);
        check("s5_drop_cnt", 32'(cnt_sink), 32'd7);
        clear_stats();
        send(12, 12, 11, 0, F_SINK, -1);
        idle(1);
        if (wq.size() > 0) begin
            check("s5_first_wren", 32'(wq[0]), 32'h40);
            check("s5_first_addr", 32'(aq[0]), 32'd0);
        end
        check("s5_end", 32'(st_end), 32'd1);

        // sop mid-frame restarts with an error
        clear_stats();
        send(12, 4, -1, 0, F_SINK, -1);
        send(12, 12, 11, 0, F_SINK, -1);
        idle(1);
        check("s6_err", 32'(st_err), 32'd1);
        check("s6_end", 32'(st_end), 32'd1);
        check("s6_writes", 32'(st_wr), 32'd16);

        // Asynchronous reset mid-frame
        clear_stats();
        send(12, 5, -1, 0, F_SINK, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        send(12, 12, 11, 20, F_SINK, -1);
        idle(2);
        check("s7_end", 32'(st_end), 32'd1);
        check("s7_err", 32'(st_err), 32'd0);
        check("s7_writes", 32'(st_wr), 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
